tdc_encoder_pipe: RTL and testbench

//  Pipelined, parametrised successor to the combinational TDC encoder.
//  - Converts a thermometer fine code plus two coarse ripple counters into a binary TDC code.
//  - Adds bubble-tolerant fine decoding, code-quality flags, valid/ready backpressure and

---
 rtl/tdc_encoder_pipe.sv | 166 ++++++++++++++++
 tb/tb_tdc_encoder_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_encoder_pipe.sv
// Three-stage pipelined TDC encoder: thermometer fine code plus coarse counters to a binary
// time code, with bubble/saturation quality flags, valid/ready backpressure and hit statistics.
module tdc_encoder_pipe #(
  parameter int unsigned FINE_W = 55,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned OUT_W  = 12,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk40M,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FINE_W-1:0] fine_raw_code,
  input  logic [CNT_W-1:0]  counterA,
  input  logic [CNT_W-1:0]  counterB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  TDC_bin_code,
  output logic [2:0]        err_flags,
  input  logic              cnt_clr,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] err_cnt
);

  localparam int unsigned FineBinW = $clog2(FINE_W + 1);
  // coarse*FINE_W + fine_bin always fits in CNT_W + FineBinW + 1 bits
  localparam int unsigned FullW    = CNT_W + FineBinW + 1;
  localparam int unsigned HalfFine = FINE_W / 2;
  localparam logic [STAT_W-1:0] StatMax = {STAT_W{1'b1}};

  logic stall;
  logic advance;

  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;

  // Stage 1: capture
  logic              s1_valid_q;
  logic [FINE_W-1:0] s1_fine_q;
  logic [CNT_W-1:0]  s1_cnt_a_q;
  logic [CNT_W-1:0]  s1_cnt_b_q;

  always_ff @(posedge clk40M or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_fine_q  <= '0;
      s1_cnt_a_q <= '0;
      s1_cnt_b_q <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_fine_q  <= fine_raw_code;
        s1_cnt_a_q <= counterA;
        s1_cnt_b_q <= counterB;
      end
    end
  end

  // Stage 2: fine decode
  logic [FineBinW-1:0] fine_bin_d;
  logic [FineBinW-1:0] trans_d;
  logic [2:0]          err_d;

  always_comb begin
    fine_bin_d = '0;
    trans_d    = '0;
    for (int i = 0; i < FINE_W; i++) begin
      fine_bin_d = fine_bin_d + FineBinW'(s1_fine_q[i]);
    end
    for (int i = 0; i < FINE_W - 1; i++) begin
      trans_d = trans_d + FineBinW'(s1_fine_q[i] ^ s1_fine_q[i+1]);
    end
    err_d[0] = trans_d > FineBinW'(1);
    err_d[1] = ~|s1_fine_q;
    err_d[2] = &s1_fine_q;
  end

  logic                s2_valid_q;
  logic [FineBinW-1:0] s2_fine_bin_q;
  logic [2:0]          s2_err_q;
  logic [CNT_W-1:0]    s2_cnt_a_q;
  logic [CNT_W-1:0]    s2_cnt_b_q;

  always_ff @(posedge clk40M or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q    <= 1'b0;
      s2_fine_bin_q <= '0;
      s2_err_q      <= '0;
      s2_cnt_a_q    <= '0;
      s2_cnt_b_q    <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_fine_bin_q <= fine_bin_d;
        s2_err_q      <= err_d;
        s2_cnt_a_q    <= s1_cnt_a_q;
        s2_cnt_b_q    <= s1_cnt_b_q;
      end
    end
  end

  // Stage 3: coarse select; a short fine count means the hit landed after the falling phase
  logic [CNT_W-1:0] coarse_d;
  logic [FullW-1:0] full_code_d;

  always_comb begin
    coarse_d    = (s2_fine_bin_q < FineBinW'(HalfFine)) ? s2_cnt_b_q : s2_cnt_a_q;
    full_code_d = FullW'(coarse_d) * FullW'(FINE_W) + FullW'(s2_fine_bin_q);
  end

  logic             out_valid_q;
  logic [OUT_W-1:0] code_q;
  logic [2:0]       err_q;

  always_ff @(posedge clk40M or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      code_q      <= '0;
      err_q       <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        code_q <= OUT_W'(full_code_d);
        err_q  <= s2_err_q;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign TDC_bin_code = code_q;
  assign err_flags    = err_q;

  // Statistics: count on output handshake, saturate, clear wins
  logic              out_hs;
  logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [STAT_W-1:0] err_cnt_q, err_cnt_d;

  assign out_hs = out_valid_q && out_ready;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d = '0;
      err_cnt_d = '0;
    end else if (out_hs) begin
      if (hit_cnt_q != StatMax) hit_cnt_d = hit_cnt_q + 1'b1;
      if ((|err_q) && (err_cnt_q != StatMax)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk40M or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign hit_cnt = hit_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_tdc_encoder_pipe.sv
// Scoreboard bench for tdc_encoder_pipe: directed TDC vectors, backpressure burst, mid-stream
// reset and randomized traffic against a popcount/transition-count reference model.
module tb_tdc_encoder_pipe;

  localparam int FW = 55;
  localparam int CW = 5;
  localparam int OW = 12;
  localparam int SW = 5;  // narrow stats so saturation is reachable quickly
  localparam int StatMax = (1 << SW) - 1;

  logic          clk40M = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] fine_raw_code = '0;
  logic [CW-1:0] counterA = '0;
  logic [CW-1:0] counterB = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] TDC_bin_code;
  logic [2:0]    err_flags;
  logic          cnt_clr = 1'b0;
  logic [SW-1:0] hit_cnt;
  logic [SW-1:0] err_cnt;

  tdc_encoder_pipe #(.FINE_W(FW), .CNT_W(CW), .OUT_W(OW), .STAT_W(SW)) dut (
    .clk40M        (clk40M),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fine_raw_code (fine_raw_code),
    .counterA      (counterA),
    .counterB      (counterB),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .TDC_bin_code  (TDC_bin_code),
    .err_flags     (err_flags),
    .cnt_clr       (cnt_clr),
    .hit_cnt       (hit_cnt),
    .err_cnt       (err_cnt)
  );

  always #12 clk40M = ~clk40M;

  typedef struct packed {
    logic [OW-1:0] code;
    logic [2:0]    err;
    logic [31:0]   stamp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  bit          lat_chk = 1'b0;
  int          exp_hit = 0;
  int          exp_err = 0;
  int          delivered = 0;
  bit          prev_stall = 1'b0;
  logic [OW-1:0] prev_code;
  logic [2:0]    prev_err;
  bit          rand_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: code = coarse*FW + ones-count, with coarse chosen by the half-line threshold
  function automatic exp_t model(input logic [FW-1:0] f, input logic [CW-1:0] a,
                                 input logic [CW-1:0] b);
    exp_t e;
    logic [FW-1:0] m;
    int pc, tr, code;
    m = '1;
    m[FW-1] = 1'b0;
    pc = $countones(f);
    tr = $countones((f ^ (f >> 1)) & m);
    code = (pc < FW / 2) ? (int'(b) * FW + pc) : (int'(a) * FW + pc);
    e.code  = code[OW-1:0];
    e.err   = {f == '1, f == '0, tr > 1};
    e.stamp = 0;
    return e;
  endfunction

  task automatic send(input logic [FW-1:0] f, input logic [CW-1:0] a, input logic [CW-1:0] b,
                      input logic [OW-1:0] code, input logic [2:0] err);
    exp_t e;
    in_valid = 1'b1;
    fine_raw_code = f;
    counterA = a;
    counterB = b;
    for (int n = 0; ; n++) begin
      @(negedge clk40M);
      if (in_ready) begin
        e.code = code;
        e.err = err;
        e.stamp = cyc;
        sb.push_back(e);
        break;
      end
      if (n > 200) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk40M);
      #1;
    end
    @(posedge clk40M);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [FW-1:0] f;
    logic [CW-1:0] a, b;
    exp_t e;
    int k;
    k = $urandom_range(0, FW);
    case ($urandom_range(0, 3))
      0: f = (k == FW) ? '1 : ((FW'(1) << k) - 1'b1);
      1: begin
        f = (k == FW) ? '1 : ((FW'(1) << k) - 1'b1);
        f[$urandom_range(0, FW - 1)] ^= 1'b1;
      end
      2: f = FW'({$urandom, $urandom});
      default: f = $urandom_range(0, 1) ? '1 : '0;
    endcase
    a = CW'($urandom);
    b = CW'($urandom);
    e = model(f, a, b);
    send(f, a, b, e.code, e.err);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk40M);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    repeat (2) @(posedge clk40M);
    #1;
  endtask

  initial forever begin
    @(posedge clk40M);
    cyc++;
  end

  // Monitor: pops on every output handshake, tracks stall stability and statistics
  initial forever begin
    exp_t e;
    bit hs;
    @(negedge clk40M);
    if (rst_n) begin
      check("hit_cnt", hit_cnt, exp_hit);
      check("err_cnt", err_cnt, exp_err);
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_code", TDC_bin_code, prev_code);
        check("stall_hold_err", err_flags, prev_err);
      end
      if (out_valid && !out_ready) check("in_ready_stalled", in_ready, 0);
      hs = out_valid && out_ready;
      if (hs) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          delivered++;
          check("code", TDC_bin_code, e.code);
          check("err_flags", err_flags, e.err);
          if (lat_chk) check("latency", cyc - e.stamp, 3);
          if (!cnt_clr) begin
            if (exp_hit < StatMax) exp_hit++;
            if (e.err != 3'b000 && exp_err < StatMax) exp_err++;
          end
        end
      end
      if (cnt_clr) begin
        exp_hit = 0;
        exp_err = 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_code = TDC_bin_code;
      prev_err = err_flags;
    end
  end

  initial begin
    #5;
    check("rst_out_valid", out_valid, 0);
    check("rst_code", TDC_bin_code, 0);
    check("rst_err", err_flags, 0);
    check("rst_hit", hit_cnt, 0);
    check("rst_errcnt", err_cnt, 0);
    @(posedge clk40M);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk40M);
    #1;

    // Directed vectors with an always-ready sink
    lat_chk = 1'b1;
    send(55'h1F, 5'd3, 5'd4, 12'd225, 3'b000);
    drain();
    send((55'd1 << 30) - 1'b1, 5'd10, 5'd11, 12'd580, 3'b000);
    send('1, 5'd31, 5'd7, 12'd1760, 3'b100);
    send('0, 5'd9, 5'd0, 12'd0, 3'b010);
    send(55'h1D, 5'd20, 5'd2, 12'd114, 3'b001);
    drain();
    lat_chk = 1'b0;

    // Reset mid-stream with samples in flight
    repeat (6) send_rand();
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_code", TDC_bin_code, 0);
    check("midrst_err", err_flags, 0);
    check("midrst_hit", hit_cnt, 0);
    check("midrst_errcnt", err_cnt, 0);
    sb.delete();
    exp_hit = 0;
    exp_err = 0;
    prev_stall = 1'b0;
    @(posedge clk40M);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk40M);
    #1;

    // Backpressure burst: 10 back-to-back samples, sink stalls 5 cycles mid-burst
    cnt_clr = 1'b1;
    @(posedge clk40M);
    #1;
    cnt_clr = 1'b0;
    delivered = 0;
    fork
      repeat (10) send_rand();
      begin
        repeat (5) @(posedge clk40M);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk40M);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", delivered, 10);
    check("bp_hit_cnt", hit_cnt, 10);

    // Randomized traffic with random sink stalls; drives the stats into saturation
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_rand();
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk40M);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk40M);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("hit_saturated", hit_cnt, StatMax);

    // One more handshake while saturated, then clear coinciding with a handshake
    send_rand();
    drain();
    check("hit_still_saturated", hit_cnt, StatMax);
    send_rand();
    for (int n = 0; n < 20; n++) begin
      @(posedge clk40M);
      #1;
      if (out_valid) begin
        cnt_clr = 1'b1;
        break;
      end
    end
    @(posedge clk40M);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk40M);
    check("clr_priority_hit", hit_cnt, 0);
    check("clr_priority_err", err_cnt, 0);
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
